// File: rtl/decoder_2to4.sv
// decoder_2to4: 2-to-4 one-hot select/strobe decoder with enable.
//
// Parameters:
//   REGISTERED     1: outputs registered on rising clk (1-cycle latency)
//                  0: outputs combinational from en/a/b (clk unused)
//   ACTIVE_LOW_OUT 0: active output = 1, others 0; 1: active = 0, others 1
//
// Ports:
//   clk    in   system clock, rising-edge active
//   rst_n  in   asynchronous active-low reset, forces all outputs inactive
//   en     in   decode enable; 0 forces all outputs inactive and valid=0
//   a      in   select bit 1 (MSB of index {a,b})
//   b      in   select bit 0 (LSB of index {a,b})
//   d0..d3 out  decoded strobes for {a,b} = 00, 01, 10, 11
//   valid  out  1 when d0..d3 reflect an enabled decode
module decoder_2to4 #(
  parameter bit REGISTERED     = 1'b1,
  parameter bit ACTIVE_LOW_OUT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic d0,
  output logic d1,
  output logic d2,
  output logic d3,
  output logic valid
);

  // Decode is done active-high internally; polarity is applied only at the
  // output so that the all-zero reset/disabled state maps to "inactive".
  logic [3:0] dec_hot;
  logic [3:0] out_hot;
  logic       out_valid;

  always_comb begin
    dec_hot = 4'b0000;
    if (en) begin
      unique case ({a, b})
        2'b00:   dec_hot = 4'b0001;
        2'b01:   dec_hot = 4'b0010;
        2'b10:   dec_hot = 4'b0100;
        2'b11:   dec_hot = 4'b1000;
        default: dec_hot = 4'b0000;
      endcase
    end
  end

  if (REGISTERED) begin : g_reg
    logic [3:0] hot_q;
    logic       valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hot_q   <= 4'b0000;
        valid_q <= 1'b0;
      end else begin
        hot_q   <= dec_hot;
        valid_q <= en;
      end
    end

    assign out_hot   = hot_q;
    assign out_valid = valid_q;
  end else begin : g_comb
    // Clock has no function in the combinational build.
    logic unused_clk;
    assign unused_clk = clk;

    assign out_hot   = rst_n ? dec_hot : 4'b0000;
    assign out_valid = rst_n & en;
  end

  assign {d3, d2, d1, d0} = out_hot ^ {4{ACTIVE_LOW_OUT}};
  assign valid            = out_valid;

endmodule

// File: tb/tb_decoder_2to4.sv
module tb_decoder_2to4;

  logic clk;
  logic rst_n;
  logic en;
  logic a;
  logic b;

  // Main DUT: registered, active-high.
  logic r_d0, r_d1, r_d2, r_d3, r_valid;
  // Registered, active-low outputs.
  logic l_d0, l_d1, l_d2, l_d3, l_valid;
  // Combinational, active-high.
  logic c_d0, c_d1, c_d2, c_d3, c_valid;

  int n_checks;
  int n_fail;

  typedef struct packed {
    logic [4:0] exp_reg;
    logic [4:0] exp_low;
  } sb_item_t;

  sb_item_t sb_q[$];

  decoder_2to4 #(.REGISTERED(1'b1), .ACTIVE_LOW_OUT(1'b0)) u_dut_reg (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b),
    .d0(r_d0), .d1(r_d1), .d2(r_d2), .d3(r_d3), .valid(r_valid)
  );

  decoder_2to4 #(.REGISTERED(1'b1), .ACTIVE_LOW_OUT(1'b1)) u_dut_low (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b),
    .d0(l_d0), .d1(l_d1), .d2(l_d2), .d3(l_d3), .valid(l_valid)
  );

  decoder_2to4 #(.REGISTERED(1'b0), .ACTIVE_LOW_OUT(1'b0)) u_dut_comb (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b),
    .d0(c_d0), .d1(c_d1), .d2(c_d2), .d3(c_d3), .valid(c_valid)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Reference model, result packed as {valid, d3, d2, d1, d0}.
  function automatic logic [4:0] model(input logic m_en, input logic m_a, input logic m_b,
                                       input logic active_low);
    logic [3:0] oh;
    logic [1:0] idx;
    idx = {m_a, m_b};
    oh  = 4'b0001 << idx;
    if (!m_en) return active_low ? 5'b01111 : 5'b00000;
    return active_low ? {1'b1, ~oh} : {1'b1, oh};
  endfunction

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] reg_out();
    return {r_valid, r_d3, r_d2, r_d1, r_d0};
  endfunction

  function automatic logic [4:0] low_out();
    return {l_valid, l_d3, l_d2, l_d1, l_d0};
  endfunction

  function automatic logic [4:0] comb_out();
    return {c_valid, c_d3, c_d2, c_d1, c_d0};
  endfunction

  // Drive one stimulus between edges, check the combinational instance at once,
  // then check both registered instances after the following rising edge.
  task automatic step(input string tag, input logic s_en, input logic s_a, input logic s_b);
    sb_item_t it;
    @(negedge clk);
    en = s_en;
    a  = s_a;
    b  = s_b;
    it.exp_reg = model(s_en, s_a, s_b, 1'b0);
    it.exp_low = model(s_en, s_a, s_b, 1'b1);
    sb_q.push_back(it);
    #1;
    check({tag, "_comb"}, comb_out(), model(s_en, s_a, s_b, 1'b0));
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 5'b00000, 5'b11111);
    end else begin
      it = sb_q.pop_front();
      check({tag, "_reg"}, reg_out(), it.exp_reg);
      check({tag, "_low"}, low_out(), it.exp_low);
      if (r_valid) check({tag, "_onehot"}, 5'($countones({r_d3, r_d2, r_d1, r_d0})), 5'd1);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    en       = 1'b1;
    a        = 1'b0;
    b        = 1'b0;

    // Reset state before any clock edge.
    #10;
    check("rst_reg", reg_out(), 5'b00000);
    check("rst_low", low_out(), 5'b01111);
    check("rst_comb", comb_out(), 5'b00000);

    @(negedge clk);
    rst_n = 1'b1;

    // Index sweep.
    step("sweep00", 1'b1, 1'b0, 1'b0);
    step("sweep01", 1'b1, 1'b0, 1'b1);
    step("sweep10", 1'b1, 1'b1, 1'b0);
    step("sweep11", 1'b1, 1'b1, 1'b1);

    // b toggles every cycle, a every two cycles, for 1000 ns.
    for (int i = 0; i < 10; i++) begin
      logic [1:0] ab;
      ab = 2'(i);
      step("toggle", 1'b1, ab[1], ab[0]);
    end

    // Enable gating.
    step("dis11", 1'b0, 1'b1, 1'b1);
    check("dis11_const", reg_out(), 5'b00000);
    step("en11", 1'b1, 1'b1, 1'b1);
    check("en11_const", reg_out(), 5'b11000);

    // Asynchronous reset between edges while d2 is active.
    step("pre_rst10", 1'b1, 1'b1, 1'b0);
    check("pre_rst_d2", reg_out(), 5'b10100);
    #20;
    rst_n = 1'b0;
    #1;
    check("mid_rst_reg", reg_out(), 5'b00000);
    check("mid_rst_low", low_out(), 5'b01111);
    check("mid_rst_comb", comb_out(), 5'b00000);
    // Held across an edge while reset stays low.
    @(posedge clk);
    #1;
    check("hold_rst_reg", reg_out(), 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst01", 1'b1, 1'b0, 1'b1);
    check("post_rst_d1", reg_out(), 5'b10010);

    // Active-low polarity.
    step("al10", 1'b1, 1'b1, 1'b0);
    check("al10_const", low_out(), 5'b11011);
    step("al_dis", 1'b0, 1'b1, 1'b0);
    check("al_dis_const", low_out(), 5'b01111);

    // Random tail.
    for (int i = 0; i < 20; i++) begin
      step("rand", 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    if (sb_q.size() != 0) check("sb_leftover", 5'(sb_q.size()), 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
